// File: rtl/fcp_pl_tx.sv
`default_nettype none
// fcp_pl_tx: FCP slave physical-layer transmitter. Serialises a PING pulse or a RESPOND
// frame (sync, start/data/parity/stop per byte, CRC-8, end sync) at UI granularity.
module fcp_pl_tx #(
  parameter int UI_CYCLES = 16,
  parameter int PING_UI   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pl_tx_en,
  input  logic        pl_tx_type,
  input  logic [15:0] pl_tx_data,
  input  logic        abort,
  output logic        tx_line,
  output logic        tx_oe,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int              c_UIW       = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;
  localparam logic [c_UIW-1:0] c_UI_LAST  = c_UIW'(UI_CYCLES - 1);
  localparam logic [15:0]     c_PING_LAST = 16'(PING_UI - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PING     = 4'd1,
    S_SYNC_H   = 4'd2,
    S_SYNC_L   = 4'd3,
    S_START    = 4'd4,
    S_DATA     = 4'd5,
    S_PARITY   = 4'd6,
    S_STOP     = 4'd7,
    S_END_SYNC = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t           r_state;
  logic [c_UIW-1:0] r_ui_cnt;
  logic [15:0]      r_cnt;
  logic [1:0]       r_left;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [7:0]       r_crc;
  logic [7:0]       r_hi;
  logic [7:0]       r_lo;
  logic             r_line;
  logic             r_oe;
  logic             r_busy;
  logic             r_done;

  logic             w_ui_end;
  logic             w_load;
  logic [7:0]       w_next_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign w_ui_end = (r_ui_cnt == c_UI_LAST);

  // r_left counts bytes not yet loaded: 3 -> high payload, 2 -> low payload, 1 -> CRC
  always_comb begin
    w_next_byte = r_crc;
    case (r_left)
      2'd3:    w_next_byte = r_hi;
      2'd2:    w_next_byte = r_lo;
      default: w_next_byte = r_crc;
    endcase
  end

  assign w_load = w_ui_end &&
                  ((r_state == S_SYNC_L) || ((r_state == S_STOP) && (r_left != 2'd0)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_ui_cnt <= '0;
      r_cnt    <= '0;
      r_left   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_crc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_line   <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state  <= S_IDLE;
      r_ui_cnt <= '0;
      r_cnt    <= '0;
      r_line   <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
        r_ui_cnt <= w_ui_end ? '0 : r_ui_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (pl_tx_en) begin
            r_hi     <= pl_tx_data[15:8];
            r_lo     <= pl_tx_data[7:0];
            r_crc    <= '0;
            r_cnt    <= '0;
            r_ui_cnt <= '0;
            r_left   <= (pl_tx_data[15:8] != 8'h00) ? 2'd3 : 2'd2;
            r_oe     <= 1'b1;
            r_busy   <= 1'b1;
            r_line   <= 1'b1;
            r_state  <= pl_tx_type ? S_SYNC_H : S_PING;
          end
        end
        S_PING: begin
          if (w_ui_end) begin
            if (r_cnt == c_PING_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_oe    <= 1'b0;
              r_line  <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_SYNC_H: begin
          if (w_ui_end) begin
            r_state <= S_SYNC_L;
            r_line  <= 1'b0;
          end
        end
        S_SYNC_L: begin
          if (w_ui_end) begin
            r_state <= S_START;
            r_line  <= 1'b1;
          end
        end
        S_START: begin
          if (w_ui_end) begin
            r_state <= S_DATA;
            r_line  <= r_shift[7];
            r_cnt   <= '0;
          end
        end
        S_DATA: begin
          if (w_ui_end) begin
            if (r_cnt == 16'd7) begin
              r_state <= S_PARITY;
              r_line  <= r_par;
            end else begin
              r_cnt   <= r_cnt + 16'd1;
              r_line  <= r_shift[6];
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end
        end
        S_PARITY: begin
          if (w_ui_end) begin
            r_state <= S_STOP;
            r_line  <= 1'b0;
          end
        end
        S_STOP: begin
          if (w_ui_end) begin
            r_state <= (r_left != 2'd0) ? S_START : S_END_SYNC;
            r_line  <= 1'b1;
          end
        end
        S_END_SYNC: begin
          if (w_ui_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_oe    <= 1'b0;
            r_line  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_oe    <= 1'b0;
          r_line  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase

      // CRC only folds in payload bytes; by the time the CRC byte is loaded it is final
      if (w_load) begin
        r_shift <= w_next_byte;
        r_par   <= ~^w_next_byte;
        r_left  <= r_left - 2'd1;
        if (r_left >= 2'd2) begin
          r_crc <= crc8_byte(r_crc, w_next_byte);
        end
      end
    end
  end

  assign tx_line = r_line;
  assign tx_oe   = r_oe;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fcp_pl_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fcp_pl_tx: frame-level reference model of the FCP transmitter compared cycle by cycle.
module tb_fcp_pl_tx;

  localparam int UI  = 16;
  localparam int PUI = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pl_tx_en = 1'b0;
  logic        pl_tx_type = 1'b0;
  logic [15:0] pl_tx_data = 16'h0;
  logic        abort = 1'b0;
  logic        tx_line, tx_oe, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit obs_q[$];

  always #5 clk = ~clk;

  fcp_pl_tx #(.UI_CYCLES(UI), .PING_UI(PUI)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pl_tx_en   (pl_tx_en),
    .pl_tx_type (pl_tx_type),
    .pl_tx_data (pl_tx_data),
    .abort      (abort),
    .tx_line    (tx_line),
    .tx_oe      (tx_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Remainder of message * x^8 modulo x^8+x^2+x+1
  function automatic logic [7:0] crc8_ref(input logic [7:0] bytes[$]);
    int rem = 0;
    int nbits = bytes.size() * 8 + 8;
    for (int i = 0; i < nbits; i++) begin
      int b = (i < bytes.size() * 8) ? int'(bytes[i / 8][7 - (i % 8)]) : 0;
      rem = (rem << 1) | b;
      if ((rem & 'h100) != 0) rem = rem ^ 'h107;
    end
    return rem[7:0];
  endfunction

  task automatic build_expected(input logic typ, input logic [15:0] data);
    logic [7:0] bytes[$];
    exp_q.delete();
    if (!typ) begin
      repeat (PUI) exp_q.push_back(1'b1);
    end else begin
      if (data[15:8] != 8'h00) bytes.push_back(data[15:8]);
      bytes.push_back(data[7:0]);
      bytes.push_back(crc8_ref(bytes));
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      foreach (bytes[j]) begin
        exp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(bytes[j][i]);
        exp_q.push_back(($countones(bytes[j]) % 2) == 0);
        exp_q.push_back(1'b0);
      end
      exp_q.push_back(1'b1);
    end
  endtask

  function automatic logic [7:0] obs_byte(input int pos);
    logic [7:0] r = 8'h0;
    for (int i = 0; i < 8; i++) r[7 - i] = obs_q[pos + i];
    return r;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of cycle N+1
  task automatic issue_req(input logic typ, input logic [15:0] data);
    pl_tx_en   = 1'b1;
    pl_tx_type = typ;
    pl_tx_data = data;
    @(negedge clk);
    pl_tx_en   = 1'b0;
  endtask

  // Walks the whole expected frame, then the DONE cycle and the following IDLE cycle
  task automatic run_frame(input string name, input int inject_at);
    int  total = exp_q.size() * UI;
    bit  seen_err = 0;
    obs_q.delete();
    for (int k = 0; k < total; k++) begin
      if (!seen_err) begin
        checks++;
        if ({tx_line, tx_oe, tx_busy, tx_done} !== {exp_q[k / UI], 1'b1, 1'b1, 1'b0}) begin
          errors++;
          seen_err = 1;
          $display("FAIL %s frame cycle %0d: line/oe/busy/done got %b required %b",
                   name, k, {tx_line, tx_oe, tx_busy, tx_done}, {exp_q[k / UI], 3'b110});
        end
      end
      if ((k % UI) == UI / 2) obs_q.push_back(tx_line);
      if (k == inject_at) begin
        pl_tx_en   = 1'b1;
        pl_tx_type = 1'($urandom);
        pl_tx_data = 16'($urandom);
      end else begin
        pl_tx_en = 1'b0;
      end
      @(negedge clk);
    end
    pl_tx_en = 1'b0;
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0001) begin
      errors++;
      $display("FAIL %s done cycle: line/oe/busy/done got %b required 0001", name,
               {tx_line, tx_oe, tx_busy, tx_done});
    end
    @(negedge clk);
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL %s after done: line/oe/busy/done got %b required 0000", name,
               {tx_line, tx_oe, tx_busy, tx_done});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b required 0000", {tx_line, tx_oe, tx_busy, tx_done});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b required 0000", {tx_line, tx_oe, tx_busy, tx_done});
    end
  endtask

  task automatic test_ping();
    build_expected(1'b0, 16'h0);
    issue_req(1'b0, 16'h0);
    run_frame("ping", -1);
  endtask

  task automatic test_write_ack();
    build_expected(1'b1, 16'h0008);
    issue_req(1'b1, 16'h0008);
    run_frame("write_ack", -1);
    checks++;
    if ({obs_q[0], obs_q[1], obs_q[2]} !== 3'b101) begin
      errors++;
      $display("FAIL write_ack_sync: got %b required 101", {obs_q[0], obs_q[1], obs_q[2]});
    end
    checks++;
    if ({obs_byte(3), obs_q[11]} !== {8'h08, 1'b0}) begin
      errors++;
      $display("FAIL write_ack_byte0: byte/parity got %h/%b required 08/0", obs_byte(3), obs_q[11]);
    end
    checks++;
    if ({obs_byte(14), obs_q[22]} !== {8'h38, 1'b0}) begin
      errors++;
      $display("FAIL write_ack_crc: byte/parity got %h/%b required 38/0", obs_byte(14), obs_q[22]);
    end
  endtask

  task automatic test_read_data();
    build_expected(1'b1, 16'h0801);
    issue_req(1'b1, 16'h0801);
    run_frame("read_data", -1);
    checks++;
    if ({obs_byte(3), obs_byte(14), obs_byte(25)} !== {8'h08, 8'h01, 8'hAF}) begin
      errors++;
      $display("FAIL read_data_bytes: got %h %h %h required 08 01 af",
               obs_byte(3), obs_byte(14), obs_byte(25));
    end
  endtask

  task automatic test_busy_reject();
    int extra = 0;
    build_expected(1'b1, 16'h0801);
    issue_req(1'b1, 16'h0801);
    run_frame("busy_reject", 100);
    repeat (20) begin
      @(negedge clk);
      if (tx_oe || tx_done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_reject_queued: active cycles after frame got %0d required 0", extra);
    end
  endtask

  task automatic test_abort();
    int stop_at = 16 * UI + 5;
    bit seen_err = 0;
    build_expected(1'b1, 16'h0801);
    issue_req(1'b1, 16'h0801);
    for (int k = 0; k < stop_at; k++) begin
      if (!seen_err) begin
        checks++;
        if ({tx_line, tx_oe, tx_done} !== {exp_q[k / UI], 1'b1, 1'b0}) begin
          errors++;
          seen_err = 1;
          $display("FAIL abort_prefix cycle %0d: line/oe/done got %b required %b", k,
                   {tx_line, tx_oe, tx_done}, {exp_q[k / UI], 2'b10});
        end
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_next: got %b required 0000", {tx_line, tx_oe, tx_busy, tx_done});
    end
    @(negedge clk);
    checks++;
    if ({tx_oe, tx_done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_done: oe/done got %b required 00", {tx_oe, tx_done});
    end
    build_expected(1'b0, 16'h0);
    issue_req(1'b0, 16'h0);
    run_frame("ping_after_abort", -1);
  endtask

  task automatic test_rst_mid_ping();
    issue_req(1'b0, 16'h0);
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_immediate: got %b required 0000", {tx_line, tx_oe, tx_busy, tx_done});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_line, tx_oe, tx_busy, tx_done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_idle: got %b required 0000", {tx_line, tx_oe, tx_busy, tx_done});
    end
    build_expected(1'b0, 16'h0);
    issue_req(1'b0, 16'h0);
    run_frame("ping_after_rst", -1);
  endtask

  task automatic test_random_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic        typ  = 1'($urandom);
      logic [15:0] data = 16'($urandom);
      if ($urandom_range(0, 1) == 0) data[15:8] = 8'h00;
      build_expected(typ, data);
      issue_req(typ, data);
      run_frame("random", -1);
    end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_write_ack();
    test_read_data();
    test_busy_reject();
    test_abort();
    test_rst_mid_ping();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
